// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator (optional frame counter under VGA_TIMING_FRAME_CNT_EN)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             Hsync,
  output logic             Vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_S   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_S   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, y_q;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  // next counter values and decode of the current (pre-advance) position
  always_comb begin
    h_d  = (h_q == H_LAST) ? '0 : h_q + CNT_W'(1);
    v_d  = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    hs_d = (h_q >= HS_S && h_q <= HS_E) ? HS_POL : ~HS_POL;
    vs_d = (v_q >= VS_S && v_q <= VS_E) ? VS_POL : ~VS_POL;
    de_d = (h_q < H_ACT) && (v_q < V_ACT);
    ls_d = (h_q == '0);
    fs_d = (h_q == '0) && (v_q == '0);
  end
  // counters and registered outputs advance on pix_en; strobes self-clear every clk
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= pix_en & ls_d;
      fs_q <= pix_en & fs_d;
      if (pix_en) begin
        h_q  <= h_d;
        v_q  <= v_d;
        x_q  <= h_q;
        y_q  <= v_q;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
      end
    end
  end
  assign Hsync       = hs_q;
  assign Vsync       = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_q;
  logic        first_q;
  // count frame starts, skipping the first frame after reset so it shows 0
  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q    <= '0;
      first_q <= 1'b1;
    end else if (pix_en && fs_d) begin
      first_q <= 1'b0;
      fc_q    <= first_q ? fc_q : fc_q + 16'd1;
    end
  end
  assign frame_cnt = fc_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table plus multi-cycle sequences for vga_timing_gen
module tb_vga_timing_gen;
  logic clk = 1'b0, reset = 1'b1, pix_en = 1'b1;
  always #5 clk = ~clk;

  logic a_hs, a_vs, a_de, a_ls, a_fs;
  logic [10:0] a_x, a_y;
  logic b_hs, b_vs, b_de, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic c_hs, c_vs, c_de, c_ls, c_fs;
  logic [10:0] c_x, c_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en), .Hsync(a_hs), .Vsync(a_vs), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(a_fc),
`endif
    .frame_start(a_fs));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en), .Hsync(b_hs), .Vsync(b_vs), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(b_fc),
`endif
    .frame_start(b_fs));

  vga_timing_gen #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_c (
    .clk(clk), .reset(reset), .pix_en(pix_en), .Hsync(c_hs), .Vsync(c_vs), .de(c_de),
    .x(c_x), .y(c_y), .line_start(c_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(c_fc),
`endif
    .frame_start(c_fs));

  typedef struct packed {
    logic       rst;
    logic       pe;
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] f;
  } vec_t;
  vec_t tbl[15];

  int tests = 0, fails = 0;
  int ax, ay, cy, bx, by, e, px, pls;
  int a_xy_bad, a_de_bad, a_hs_bad, a_hs_low_n, a_hs_fx, a_ls_bad, a_fs_bad, ls1, ls2, ls3;
  int c_xy_bad, c_de_bad, c_vs_bad, c_vs_low_n, fall_x, fall_y, rise_x, rise_y, cvs_prev, c_fs2;
  int b_x_bad, b_sync_bad, b_fs_bad, fc_bad, hold_bad, wide_bad, x2_bad, found;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst pe x y {hs vs de ls fs} for the small HS_POL=VS_POL=1 instance
    tbl[0]  = '{1'b1, 1'b1, 4'd0, 4'd0, 5'b00000};
    tbl[1]  = '{1'b1, 1'b1, 4'd0, 4'd0, 5'b00000};
    tbl[2]  = '{1'b0, 1'b1, 4'd0, 4'd0, 5'b00111};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 4'd0, 5'b00100};
    tbl[4]  = '{1'b0, 1'b1, 4'd1, 4'd0, 5'b00100};
    tbl[5]  = '{1'b0, 1'b1, 4'd2, 4'd0, 5'b00100};
    tbl[6]  = '{1'b0, 1'b1, 4'd3, 4'd0, 5'b00100};
    tbl[7]  = '{1'b0, 1'b1, 4'd4, 4'd0, 5'b00000};
    tbl[8]  = '{1'b0, 1'b1, 4'd5, 4'd0, 5'b10000};
    tbl[9]  = '{1'b0, 1'b0, 4'd5, 4'd0, 5'b10000};
    tbl[10] = '{1'b0, 1'b1, 4'd6, 4'd0, 5'b10000};
    tbl[11] = '{1'b0, 1'b1, 4'd7, 4'd0, 5'b00000};
    tbl[12] = '{1'b0, 1'b1, 4'd0, 4'd1, 5'b00110};
    tbl[13] = '{1'b1, 1'b1, 4'd0, 4'd0, 5'b00000};
    tbl[14] = '{1'b0, 1'b1, 4'd0, 4'd0, 5'b00111};
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst;
      pix_en = tbl[i].pe;
      tick;
      chk($sformatf("vec%0d", i), {b_x, b_y, b_hs, b_vs, b_de, b_ls, b_fs},
          {tbl[i].x, tbl[i].y, tbl[i].f});
    end

    reset = 1'b1;
    pix_en = 1'b1;
    repeat (5) tick;
    chk("a_reset", {a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs}, {3'b110, 22'd0, 2'b00});

    a_xy_bad = 0; a_de_bad = 0; a_hs_bad = 0; a_hs_low_n = 0; a_hs_fx = -1; a_ls_bad = 0;
    a_fs_bad = 0; ls1 = 0; ls2 = 0; c_xy_bad = 0; c_de_bad = 0; c_vs_bad = 0; c_vs_low_n = 0;
    fall_x = -1; fall_y = -1; rise_x = -1; rise_y = -1; cvs_prev = 1; c_fs2 = 0;
    b_x_bad = 0; b_sync_bad = 0; b_fs_bad = 0; fc_bad = 0;
    reset = 1'b0;
    for (int k = 1; k <= 12001; k++) begin
      tick;
      ax = (k - 1) % 800; ay = (k - 1) / 800; cy = ay % 15;
      bx = (k - 1) % 8; by = ((k - 1) / 8) % 5;
      if (a_x !== 11'(ax) || a_y !== 11'(ay)) a_xy_bad++;
      if (a_de !== (ax < 640)) a_de_bad++;
      if (a_hs !== !(ax >= 656 && ax < 752)) a_hs_bad++;
      if (k <= 800 && a_hs === 1'b0) a_hs_low_n++;
      if (a_hs === 1'b0 && a_hs_fx < 0) a_hs_fx = int'(a_x);
      if (a_ls !== (ax == 0)) a_ls_bad++;
      if (a_ls === 1'b1) begin
        if (ls1 == 0) ls1 = k;
        else if (ls2 == 0) ls2 = k;
      end
      if (a_fs !== (k == 1)) a_fs_bad++;
      if (c_x !== 11'(ax) || c_y !== 11'(cy)) c_xy_bad++;
      if (c_de !== (ax < 640 && cy < 8)) c_de_bad++;
      if (c_vs !== !(cy == 10 || cy == 11)) c_vs_bad++;
      if (c_vs === 1'b0) c_vs_low_n++;
      if (c_vs === 1'b0 && cvs_prev == 1 && fall_x < 0) begin fall_x = int'(c_x); fall_y = int'(c_y); end
      if (c_vs === 1'b1 && cvs_prev == 0 && rise_x < 0) begin rise_x = int'(c_x); rise_y = int'(c_y); end
      cvs_prev = int'(c_vs);
      if (c_fs === 1'b1 && k > 1) c_fs2 = k;
      if (b_x !== 4'(bx) || b_y !== 4'(by)) b_x_bad++;
      if (b_hs !== (bx == 5 || bx == 6) || b_vs !== (by == 3)) b_sync_bad++;
      if (b_fs !== ((k - 1) % 40 == 0)) b_fs_bad++;
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (c_fc !== 16'((k > 12000) ? 1 : 0) || b_fc !== 16'((k - 1) / 40)) fc_bad++;
`endif
    end
    chk("a_xy_track", a_xy_bad, 0);
    chk("a_de_window", a_de_bad, 0);
    chk("a_hsync_window", a_hs_bad, 0);
    chk("a_hsync_low_len", a_hs_low_n, 96);
    chk("a_hsync_first_x", a_hs_fx, 656);
    chk("a_line_start", a_ls_bad, 0);
    chk("a_line_period", ls2 - ls1, 800);
    chk("a_frame_start", a_fs_bad, 0);
    chk("c_xy_track", c_xy_bad, 0);
    chk("c_de_blank_lines", c_de_bad, 0);
    chk("c_vsync_window", c_vs_bad, 0);
    chk("c_vsync_low_len", c_vs_low_n, 1600);
    chk("c_vsync_fall_x", fall_x, 0);
    chk("c_vsync_fall_y", fall_y, 10);
    chk("c_vsync_rise_x", rise_x, 0);
    chk("c_vsync_rise_y", rise_y, 12);
    chk("c_frame_period", c_fs2, 12001);
    chk("b_xy_seq", b_x_bad, 0);
    chk("b_sync_pol", b_sync_bad, 0);
    chk("b_frame_40", b_fs_bad, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt_seq", fc_bad, 0);
`endif

    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    hold_bad = 0; wide_bad = 0; x2_bad = 0; ls1 = 0; ls2 = 0; ls3 = 0; px = 0; pls = 0;
    for (int k = 1; k <= 3300; k++) begin
      pix_en = 1'(k % 2);
      tick;
      e = (k + 1) / 2;
      if (a_x !== 11'((e - 1) % 800)) x2_bad++;
      if (!pix_en && int'(a_x) != px) hold_bad++;
      if (a_ls === 1'b1 && pls == 1) wide_bad++;
      if (a_fs === 1'b1 && k > 1) wide_bad++;
      if (a_ls === 1'b1) begin
        if (ls1 == 0) ls1 = k;
        else if (ls2 == 0) ls2 = k;
        else if (ls3 == 0) ls3 = k;
      end
      px = int'(a_x);
      pls = int'(a_ls);
    end
    chk("half_x_track", x2_bad, 0);
    chk("half_x_hold", hold_bad, 0);
    chk("half_strobe_width", wide_bad, 0);
    chk("half_line_period", ls2 - ls1, 1600);
    chk("half_line_period2", ls3 - ls2, 1600);

    pix_en = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 10000 && found == 0; i++) begin
      tick;
      found = (c_x == 11'd300 && c_y == 11'd5) ? 1 : 0;
    end
    chk("mid_reach", found, 1);
    reset = 1'b1;
    tick;
    chk("mid_reset_vals", {c_hs, c_vs, c_de, c_x, c_y, c_ls, c_fs}, {3'b110, 22'd0, 2'b00});
    reset = 1'b0;
    tick;
    chk("mid_release", {c_x, c_y, c_de, c_ls, c_fs}, {22'd0, 3'b111});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("mid_frame_cnt", b_fc, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
